acc_control_fsm: RTL and testbench

//  Multi-cycle control FSM for the 16-bit accumulator processor. Sequences fetch, decode and

---
 rtl/acc_control_fsm_pkg.sv | 66 ++++++
 rtl/acc_control_fsm_mem_wait_timer.sv | 20 ++
 rtl/acc_control_fsm.sv | 113 +++++++++++
 tb/tb_acc_control_fsm.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/acc_control_fsm_pkg.sv
// acc_control_fsm_pkg: shared opcode, mux-select and state encodings for the accumulator processor
package acc_control_fsm_pkg;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_LI   = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_LRA  = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_BNE  = 4'h9;
  localparam logic [3:0] OP_J    = 4'hA;
  localparam logic [3:0] OP_JAL  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [1:0] ACC_SRC_RA  = 2'd0;
  localparam logic [1:0] ACC_SRC_IMM = 2'd1;
  localparam logic [1:0] ACC_SRC_MDR = 2'd2;
  localparam logic [1:0] ACC_SRC_ALU = 2'd3;
  localparam logic [1:0] PC_SRC_INC = 2'd0;
  localparam logic [1:0] PC_SRC_BR  = 2'd1;
  localparam logic [1:0] PC_SRC_JMP = 2'd2;
  localparam logic [2:0] ALU_OP_ADD = 3'd0;
  localparam logic [2:0] ALU_OP_SUB = 3'd1;
  localparam logic [2:0] ALU_OP_AND = 3'd2;
  localparam logic [2:0] ALU_OP_OR  = 3'd3;
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEM_RD = 4'd2;
  localparam logic [3:0] S_ALU_WB = 4'd3;
  localparam logic [3:0] S_LW_WB  = 4'd4;
  localparam logic [3:0] S_LI_WB  = 4'd5;
  localparam logic [3:0] S_LRA_WB = 4'd6;
  localparam logic [3:0] S_MEM_WR = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_HALT   = 4'd10;
  localparam logic [3:0] S_ERR    = 4'd11;
  typedef struct packed {
    logic [1:0] acc_src;
    logic       acc_write;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       ir_write;
    logic       mdr_write;
    logic       ra_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       halted;
    logic       bus_err;
  } ctrl_t;
  function automatic logic [3:0] decode_next(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LW: return S_MEM_RD;
      OP_LI:          return S_LI_WB;
      OP_SW:          return S_MEM_WR;
      OP_LRA:         return S_LRA_WB;
      OP_BEQ, OP_BNE: return S_BRANCH;
      OP_J, OP_JAL:   return S_JUMP;
      OP_HALT:        return S_HALT;
      default:        return S_FETCH;
    endcase
  endfunction
endpackage

// File: rtl/acc_control_fsm_mem_wait_timer.sv
// mem_wait_timer: counts not-ready cycles of one memory access and flags a hung access
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic ready,
  output logic timeout
);
  localparam int W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst || clr || ready) r_cnt <= '0;
    else if (en) r_cnt <= r_cnt + 1'b1;
  end
  // ready in the final allowed cycle still completes the access
  assign timeout = (MEM_TIMEOUT != 0) && en && !ready && (r_cnt == W'(MEM_TIMEOUT - 1));
endmodule

// File: rtl/acc_control_fsm.sv
// acc_control_fsm: multi-cycle fetch/decode/execute controller driving the accumulator datapath
module acc_control_fsm
  import acc_control_fsm_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       acc_zero,
  input  logic       mem_ready,
  output logic [1:0] acc_src,
  output logic       acc_write,
  output logic [2:0] alu_op,
  output logic [1:0] pc_src,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       ra_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       halted,
  output logic       bus_err
);
  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       w_mem;
  logic       w_timeout;
  ctrl_t      w_c;
  assign w_mem = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk(clk), .rst(reset), .clr(!w_mem), .en(w_mem), .ready(mem_ready), .timeout(w_timeout)
  );
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : w_timeout ? S_ERR : S_FETCH;
      S_DECODE: w_next = decode_next(opcode);
      S_MEM_RD: w_next = mem_ready ? ((opcode == OP_LW) ? S_LW_WB : S_ALU_WB) : w_timeout ? S_ERR : S_MEM_RD;
      S_MEM_WR: w_next = mem_ready ? S_FETCH : w_timeout ? S_ERR : S_MEM_WR;
      S_HALT:   w_next = S_HALT;
      S_ERR:    w_next = S_ERR;
      default:  w_next = S_FETCH;
    endcase
  end
  always_comb begin
    w_c = '0;
    case (r_state)
      S_FETCH: begin
        w_c.mem_read = 1'b1;
        w_c.ir_write = mem_ready;
        w_c.pc_write = mem_ready;
        w_c.pc_src   = PC_SRC_INC;
      end
      S_MEM_RD: begin
        w_c.mem_read  = 1'b1;
        w_c.iord      = 1'b1;
        w_c.mdr_write = mem_ready;
      end
      S_ALU_WB: begin
        w_c.alu_op    = {1'b0, opcode[1:0]};
        w_c.acc_src   = ACC_SRC_ALU;
        w_c.acc_write = 1'b1;
      end
      S_LW_WB: begin
        w_c.acc_src   = ACC_SRC_MDR;
        w_c.acc_write = 1'b1;
      end
      S_LI_WB: begin
        w_c.acc_src   = ACC_SRC_IMM;
        w_c.acc_write = 1'b1;
      end
      S_LRA_WB: begin
        w_c.acc_src   = ACC_SRC_RA;
        w_c.acc_write = 1'b1;
      end
      S_MEM_WR: begin
        w_c.mem_write = 1'b1;
        w_c.iord      = 1'b1;
      end
      S_BRANCH: begin
        w_c.pc_src   = PC_SRC_BR;
        w_c.pc_write = (opcode == OP_BNE) ? !acc_zero : acc_zero;
      end
      S_JUMP: begin
        w_c.pc_src   = PC_SRC_JMP;
        w_c.pc_write = 1'b1;
        w_c.ra_write = (opcode == OP_JAL);
      end
      S_HALT:  w_c.halted  = 1'b1;
      S_ERR:   w_c.bus_err = 1'b1;
      default: w_c = '0;
    endcase
  end
  assign acc_src   = w_c.acc_src;
  assign acc_write = w_c.acc_write;
  assign alu_op    = w_c.alu_op;
  assign pc_src    = w_c.pc_src;
  assign pc_write  = w_c.pc_write;
  assign ir_write  = w_c.ir_write;
  assign mdr_write = w_c.mdr_write;
  assign ra_write  = w_c.ra_write;
  assign iord      = w_c.iord;
  assign mem_read  = w_c.mem_read;
  assign mem_write = w_c.mem_write;
  assign halted    = w_c.halted;
  assign bus_err   = w_c.bus_err;
endmodule

// File: tb/tb_acc_control_fsm.sv
// tb_acc_control_fsm: vector-table and scoreboard checks of the controller at default and short timeouts
module tb_acc_control_fsm;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       reset, acc_zero, mem_ready;
  logic [3:0] opcode;
  logic [1:0] acc_src, pc_src;
  logic [2:0] alu_op;
  logic       acc_write, pc_write, ir_write, mdr_write, ra_write, iord, mem_read, mem_write, halted, bus_err;
  logic       reset3, acc_zero3, mem_ready3;
  logic [3:0] opcode3;
  logic [1:0] acc_src3, pc_src3;
  logic [2:0] alu_op3;
  logic       acc_write3, pc_write3, ir_write3, mdr_write3, ra_write3, iord3, mem_read3, mem_write3, halted3, bus_err3;
  acc_control_fsm u_dut (
    .clk(clk), .reset(reset), .opcode(opcode), .acc_zero(acc_zero), .mem_ready(mem_ready),
    .acc_src(acc_src), .acc_write(acc_write), .alu_op(alu_op), .pc_src(pc_src), .pc_write(pc_write),
    .ir_write(ir_write), .mdr_write(mdr_write), .ra_write(ra_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .halted(halted), .bus_err(bus_err)
  );
  acc_control_fsm #(.MEM_TIMEOUT(3)) u_dut3 (
    .clk(clk), .reset(reset3), .opcode(opcode3), .acc_zero(acc_zero3), .mem_ready(mem_ready3),
    .acc_src(acc_src3), .acc_write(acc_write3), .alu_op(alu_op3), .pc_src(pc_src3), .pc_write(pc_write3),
    .ir_write(ir_write3), .mdr_write(mdr_write3), .ra_write(ra_write3), .iord(iord3), .mem_read(mem_read3),
    .mem_write(mem_write3), .halted(halted3), .bus_err(bus_err3)
  );
  logic [16:0] w_out, w_out3;
  assign w_out  = {acc_src, acc_write, alu_op, pc_src, pc_write, ir_write, mdr_write, ra_write,
                   iord, mem_read, mem_write, halted, bus_err};
  assign w_out3 = {acc_src3, acc_write3, alu_op3, pc_src3, pc_write3, ir_write3, mdr_write3, ra_write3,
                   iord3, mem_read3, mem_write3, halted3, bus_err3};
  function automatic logic [16:0] e(input int as, aw, op, ps, pw, iw, mw, rw, io, mr, wr, h, be);
    return {as[1:0], aw[0], op[2:0], ps[1:0], pw[0], iw[0], mw[0], rw[0], io[0], mr[0], wr[0], h[0], be[0]};
  endfunction
  localparam logic [16:0] NONE = 17'h0;
  localparam logic [16:0] F_W  = e(0,0,0,0,0,0,0,0,0,1,0,0,0);
  localparam logic [16:0] F_R  = e(0,0,0,0,1,1,0,0,0,1,0,0,0);
  localparam logic [16:0] RD_W = e(0,0,0,0,0,0,0,0,1,1,0,0,0);
  localparam logic [16:0] RD_R = e(0,0,0,0,0,0,1,0,1,1,0,0,0);
  localparam logic [16:0] WR   = e(0,0,0,0,0,0,0,0,1,0,1,0,0);
  localparam logic [16:0] LI   = e(1,1,0,0,0,0,0,0,0,0,0,0,0);
  localparam logic [16:0] LW   = e(2,1,0,0,0,0,0,0,0,0,0,0,0);
  localparam logic [16:0] LRA  = e(0,1,0,0,0,0,0,0,0,0,0,0,0);
  localparam logic [16:0] SUB  = e(3,1,1,0,0,0,0,0,0,0,0,0,0);
  localparam logic [16:0] ORW  = e(3,1,3,0,0,0,0,0,0,0,0,0,0);
  localparam logic [16:0] BR0  = e(0,0,0,1,0,0,0,0,0,0,0,0,0);
  localparam logic [16:0] BR1  = e(0,0,0,1,1,0,0,0,0,0,0,0,0);
  localparam logic [16:0] JMP  = e(0,0,0,2,1,0,0,0,0,0,0,0,0);
  localparam logic [16:0] JAL  = e(0,0,0,2,1,0,0,1,0,0,0,0,0);
  localparam logic [16:0] HLT  = e(0,0,0,0,0,0,0,0,0,0,0,1,0);
  localparam logic [16:0] ERR  = e(0,0,0,0,0,0,0,0,0,0,0,0,1);
  typedef struct {
    logic        rst;
    logic [3:0]  op;
    logic        az;
    logic        rdy;
    logic [16:0] exp;
  } vec_t;
  vec_t        tbl[$];
  logic [16:0] sb[$];
  int          checks = 0;
  int          errors = 0;
  task automatic step(input bit d3, input logic rst, input logic [3:0] op, input logic az,
                      input logic rdy, input logic [16:0] exp, input string name);
    logic [16:0] want, got;
    if (d3) begin
      reset3 = rst; opcode3 = op; acc_zero3 = az; mem_ready3 = rdy;
    end else begin
      reset = rst; opcode = op; acc_zero = az; mem_ready = rdy;
    end
    sb.push_back(exp);
    @(negedge clk);
    want = sb.pop_front();
    got  = d3 ? w_out3 : w_out;
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b1; opcode = 4'h0; acc_zero = 1'b0; mem_ready = 1'b0;
    reset3 = 1'b1; opcode3 = 4'h0; acc_zero3 = 1'b0; mem_ready3 = 1'b0;
    tbl.push_back('{0, 4'h4, 0, 1, F_R});
    tbl.push_back('{0, 4'h4, 0, 1, NONE});
    tbl.push_back('{0, 4'h4, 0, 1, LI});
    tbl.push_back('{0, 4'h5, 0, 1, F_R});
    tbl.push_back('{0, 4'h5, 0, 0, NONE});
    tbl.push_back('{0, 4'h5, 0, 0, RD_W});
    tbl.push_back('{0, 4'h5, 0, 0, RD_W});
    tbl.push_back('{0, 4'h5, 0, 0, RD_W});
    tbl.push_back('{0, 4'h5, 0, 1, RD_R});
    tbl.push_back('{0, 4'h5, 0, 0, LW});
    tbl.push_back('{0, 4'h1, 0, 1, F_R});
    tbl.push_back('{0, 4'h1, 0, 0, NONE});
    tbl.push_back('{0, 4'h1, 0, 1, RD_R});
    tbl.push_back('{0, 4'h1, 0, 0, SUB});
    tbl.push_back('{0, 4'h3, 0, 1, F_R});
    tbl.push_back('{0, 4'h3, 0, 0, NONE});
    tbl.push_back('{0, 4'h3, 0, 1, RD_R});
    tbl.push_back('{0, 4'h3, 0, 0, ORW});
    tbl.push_back('{0, 4'h7, 0, 1, F_R});
    tbl.push_back('{0, 4'h7, 0, 1, NONE});
    tbl.push_back('{0, 4'h7, 0, 1, LRA});
    tbl.push_back('{0, 4'h8, 0, 1, F_R});
    tbl.push_back('{0, 4'h8, 0, 1, NONE});
    tbl.push_back('{0, 4'h8, 0, 1, BR0});
    tbl.push_back('{0, 4'h8, 1, 1, F_R});
    tbl.push_back('{0, 4'h8, 1, 1, NONE});
    tbl.push_back('{0, 4'h8, 1, 1, BR1});
    tbl.push_back('{0, 4'h9, 1, 1, F_R});
    tbl.push_back('{0, 4'h9, 1, 1, NONE});
    tbl.push_back('{0, 4'h9, 1, 1, BR0});
    tbl.push_back('{0, 4'h9, 0, 1, F_R});
    tbl.push_back('{0, 4'h9, 0, 1, NONE});
    tbl.push_back('{0, 4'h9, 0, 1, BR1});
    tbl.push_back('{0, 4'hA, 0, 1, F_R});
    tbl.push_back('{0, 4'hA, 0, 1, NONE});
    tbl.push_back('{0, 4'hA, 0, 1, JMP});
    tbl.push_back('{0, 4'hB, 0, 1, F_R});
    tbl.push_back('{0, 4'hB, 0, 1, NONE});
    tbl.push_back('{0, 4'hB, 0, 1, JAL});
    tbl.push_back('{0, 4'hC, 0, 1, F_R});
    tbl.push_back('{0, 4'hC, 0, 1, NONE});
    tbl.push_back('{0, 4'h6, 0, 0, F_W});
    tbl.push_back('{0, 4'h6, 0, 1, F_R});
    tbl.push_back('{0, 4'h6, 0, 1, NONE});
    tbl.push_back('{0, 4'h6, 0, 1, WR});
    tbl.push_back('{0, 4'h6, 0, 1, F_R});
    tbl.push_back('{0, 4'h6, 0, 0, NONE});
    tbl.push_back('{0, 4'h6, 0, 0, WR});
    tbl.push_back('{1, 4'h6, 0, 0, WR});
    tbl.push_back('{0, 4'h6, 0, 0, F_W});
    repeat (2) @(posedge clk);
    #1;
    foreach (tbl[i]) step(0, tbl[i].rst, tbl[i].op, tbl[i].az, tbl[i].rdy, tbl[i].exp, $sformatf("vec%0d", i));
    // halt is sticky until reset
    step(0, 0, 4'hF, 0, 1, F_R, "halt_fetch");
    step(0, 0, 4'hF, 0, 1, NONE, "halt_decode");
    for (int i = 0; i < 20; i++) step(0, 0, 4'hF, i[0], 1, HLT, $sformatf("halt_hold%0d", i));
    step(0, 1, 4'hF, 0, 1, HLT, "halt_reset");
    // default timeout: 15 held cycles then error, sticky
    for (int i = 0; i < 15; i++) step(0, 0, 4'h0, 0, 0, F_W, $sformatf("to15_req%0d", i));
    for (int i = 0; i < 3; i++) step(0, 0, 4'h0, 0, 1, ERR, $sformatf("to15_err%0d", i));
    step(0, 1, 4'h0, 0, 1, ERR, "to15_reset");
    step(0, 0, 4'h0, 0, 1, F_R, "to15_after");
    // short-timeout instance
    for (int i = 0; i < 3; i++) step(1, 0, 4'h0, 0, 0, F_W, $sformatf("to3_req%0d", i));
    for (int i = 0; i < 4; i++) step(1, 0, 4'h0, 0, i[0], ERR, $sformatf("to3_err%0d", i));
    step(1, 1, 4'h0, 0, 0, ERR, "to3_reset");
    step(1, 0, 4'h4, 0, 0, F_W, "to3_late0");
    step(1, 0, 4'h4, 0, 0, F_W, "to3_late1");
    step(1, 0, 4'h4, 0, 1, F_R, "to3_late_ready");
    step(1, 0, 4'h4, 0, 0, NONE, "to3_decode");
    step(1, 0, 4'h4, 0, 0, LI, "to3_li");
    step(1, 0, 4'h4, 0, 0, F_W, "to3_fetch");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
